pc_flow_ctrl: RTL and testbench

Sequencing controller for the program counter of the RV32I pipeline. It resolves competing next-PC events (jalr, jal, taken branch, load-use hazard, instruction-memory wait, halt) into the one-hot control set the PC register consumes: jalr, UJ_en, b_en, stall. It also issues pipeline flush/bubble signals and keeps performance counters. It sits between the EX-stage branch/jump resolution, the hazard detector and the PC register.

---
 rtl/rv32i_ctrl_pkg.sv | 23 ++
 rtl/sat_counter.sv | 31 +++
 rtl/pc_flow_ctrl.sv | 122 ++++++++++++
 tb/tb_pc_flow_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Encodings shared by the PC register, hazard unit and PC flow controller.
// Keeping them here stops the three blocks drifting apart.
package rv32i_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        FLUSH    = 2'd2,
        HALT     = 2'd3
    } pc_flow_state_t;

    // One-hot next-PC select; PC_SEL_SEQ (all zero) means PC + 4.
    typedef enum logic [3:0] {
        PC_SEL_SEQ   = 4'b0000,
        PC_SEL_JALR  = 4'b0001,
        PC_SEL_JAL   = 4'b0010,
        PC_SEL_BR    = 4'b0100,
        PC_SEL_STALL = 4'b1000
    } pc_sel_t;

    localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_flow_ctrl.sv
// Resolves competing next-PC events into a one-hot PC select, drives
// pipeline flush/bubble controls and counts redirects and stall cycles.
module pc_flow_ctrl
    import rv32i_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             jalr_req,
    input  logic             jal_req,
    input  logic             br_taken,
    input  logic             load_use,
    input  logic             imem_ready,
    input  logic             halt_req,
    output logic             jalr,
    output logic             UJ_en,
    output logic             b_en,
    output logic             stall,
    output logic             flush_if,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output pc_flow_state_t   dbg_state
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    pc_flow_state_t          state_q, state_d;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    pc_sel_t                 sel;
    logic                    flush;
    logic                    bubble;
    logic                    redirect;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        sel         = PC_SEL_SEQ;
        flush       = 1'b0;
        bubble      = 1'b0;
        redirect    = 1'b0;
        case (state_q)
            RUN, WAIT_MEM: begin
                if (halt_req) begin
                    sel     = PC_SEL_STALL;
                    state_d = HALT;
                end else if (jalr_req || jal_req || br_taken) begin
                    sel         = jalr_req ? PC_SEL_JALR :
                                  jal_req  ? PC_SEL_JAL  : PC_SEL_BR;
                    flush       = 1'b1;
                    redirect    = 1'b1;
                    flush_cnt_d = FLUSH_INIT;
                    state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                end else if (load_use) begin
                    // Hold PC and bubble EX; stay in whichever state we were in.
                    sel    = PC_SEL_STALL;
                    bubble = 1'b1;
                end else if (!imem_ready) begin
                    sel     = PC_SEL_STALL;
                    state_d = WAIT_MEM;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                // Requests seen here belong to squashed instructions.
                flush = 1'b1;
                if (!imem_ready) begin
                    sel = PC_SEL_STALL;
                end
                if (flush_cnt_q != '0) begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
                if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
                    state_d = imem_ready ? RUN : WAIT_MEM;
                end
            end
            HALT: begin
                sel = PC_SEL_STALL;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign {stall, b_en, UJ_en, jalr} = sel;
    assign flush_if  = flush;
    assign flush_id  = flush;
    assign bubble_ex = bubble;
    assign halted    = (state_q == HALT);
    assign dbg_state = state_q;

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect),
        .count (redirect_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (sel == PC_SEL_STALL),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: directed vector table plus randomized traffic
// against an event-level reference model, on two parameterizations.
module tb_pc_flow_ctrl;
    import rv32i_ctrl_pkg::*;

    typedef struct packed {
        logic jalr, uj, b, stall, fi, fid, bub, halted;
        pc_flow_state_t st;
    } outs_t;

    typedef struct packed {
        logic [5:0] in;   // {jalr_req, jal_req, br_taken, load_use, imem_ready, halt_req}
        outs_t      exp;
    } vec_t;

    // ---------------- clock / reset / DUTs ----------------
    logic clk = 1'b0;
    logic reset;
    logic jalr_req, jal_req, br_taken, load_use, imem_ready, halt_req;

    logic jalr_a, uj_a, b_a, stall_a, fi_a, fid_a, bub_a, halted_a;
    logic [31:0] redir_a, scnt_a;
    pc_flow_state_t st_a;
    logic jalr_b, uj_b, b_b, stall_b, fi_b, fid_b, bub_b, halted_b;
    logic [3:0] redir_b, scnt_b;
    pc_flow_state_t st_b;

    always #5 clk = ~clk;

    pc_flow_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .jalr_req(jalr_req), .jal_req(jal_req),
        .br_taken(br_taken), .load_use(load_use), .imem_ready(imem_ready),
        .halt_req(halt_req), .jalr(jalr_a), .UJ_en(uj_a), .b_en(b_a),
        .stall(stall_a), .flush_if(fi_a), .flush_id(fid_a), .bubble_ex(bub_a),
        .halted(halted_a), .redirect_cnt(redir_a), .stall_cnt(scnt_a),
        .dbg_state(st_a)
    );

    pc_flow_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .jalr_req(jalr_req), .jal_req(jal_req),
        .br_taken(br_taken), .load_use(load_use), .imem_ready(imem_ready),
        .halt_req(halt_req), .jalr(jalr_b), .UJ_en(uj_b), .b_en(b_b),
        .stall(stall_b), .flush_if(fi_b), .flush_id(fid_b), .bubble_ex(bub_b),
        .halted(halted_b), .redirect_cnt(redir_b), .stall_cnt(scnt_b),
        .dbg_state(st_b)
    );

    // ---------------- reference model ----------------
    int     total = 0;
    int     bad   = 0;
    bit     m_halt  [2];
    bit     m_wait  [2];
    int     m_flush [2];
    longint m_redir [2];
    longint m_stall [2];
    int     fc      [2] = '{2, 1};
    longint cmax    [2] = '{64'hFFFF_FFFF, 64'd15};
    logic [9:0] exp_q[$];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_halt[k] = 0; m_wait[k] = 0; m_flush[k] = 0;
            m_redir[k] = 0; m_stall[k] = 0;
        end
    endtask

    // Evaluates one cycle for instance k from the current inputs; commit advances it.
    task automatic model_cycle(input int k, input bit commit, output outs_t o);
        bit nh, nw, ir;
        int nf;
        o = '0;
        nh = m_halt[k]; nw = m_wait[k]; nf = m_flush[k]; ir = 0;
        if (m_halt[k]) begin
            o.st = HALT; o.stall = 1; o.halted = 1;
        end else if (m_flush[k] > 0) begin
            o.st = FLUSH; o.fi = 1; o.fid = 1; o.stall = !imem_ready;
            nf = m_flush[k] - 1;
            if (nf == 0) nw = !imem_ready;
        end else begin
            o.st = m_wait[k] ? WAIT_MEM : RUN;
            if (halt_req) begin
                o.stall = 1; nh = 1;
            end else if (jalr_req || jal_req || br_taken) begin
                if (jalr_req) o.jalr = 1;
                else if (jal_req) o.uj = 1;
                else o.b = 1;
                o.fi = 1; o.fid = 1; ir = 1;
                nf = fc[k] - 1; nw = 0;
            end else if (load_use) begin
                o.stall = 1; o.bub = 1;
            end else if (!imem_ready) begin
                o.stall = 1; nw = 1;
            end else begin
                nw = 0;
            end
        end
        if (commit) begin
            m_halt[k] = nh; m_wait[k] = nw; m_flush[k] = nf;
            if (ir && m_redir[k] < cmax[k]) m_redir[k]++;
            if (o.stall && m_stall[k] < cmax[k]) m_stall[k]++;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        {jalr_req, jal_req, br_taken, load_use, halt_req} = 5'($urandom);
        imem_ready = 1'($urandom);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic [5:0] in, input bit use_tab, input outs_t tab_exp);
        outs_t o;
        logic [9:0] e;
        {jalr_req, jal_req, br_taken, load_use, imem_ready, halt_req} = in;
        for (int k = 0; k < 2; k++) begin
            model_cycle(k, 1'b0, o);
            exp_q.push_back(o);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        check("outs_a", {jalr_a, uj_a, b_a, stall_a, fi_a, fid_a, bub_a, halted_a, st_a}, e);
        e = exp_q.pop_front();
        check("outs_b", {jalr_b, uj_b, b_b, stall_b, fi_b, fid_b, bub_b, halted_b, st_b}, e);
        check("redirect_cnt_a", redir_a, m_redir[0]);
        check("stall_cnt_a", scnt_a, m_stall[0]);
        check("redirect_cnt_b", redir_b, m_redir[1]);
        check("stall_cnt_b", scnt_b, m_stall[1]);
        if (use_tab) check("table_a", {jalr_a, uj_a, b_a, stall_a, fi_a, fid_a, bub_a, halted_a, st_a}, tab_exp);
        for (int k = 0; k < 2; k++) model_cycle(k, 1'b1, o);
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input logic [5:0] in, input logic [7:0] o, input pc_flow_state_t st);
        vec_t v;
        v.in  = in;
        v.exp = {o, st};
        return v;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        vec_t vt[23];
        logic [5:0] rin;

        reset = 1'b0;
        {jalr_req, jal_req, br_taken, load_use, imem_ready, halt_req} = '0;
        model_reset();

        // in: {jalr, jal, br, load_use, imem_ready, halt}
        // out: {jalr, UJ_en, b_en, stall, flush_if, flush_id, bubble_ex, halted}
        for (int i = 0; i < 5; i++) vt[i] = mk(6'b000010, 8'b0000_0000, RUN);
        vt[5]  = mk(6'b011010, 8'b0100_1100, RUN);
        vt[6]  = mk(6'b001010, 8'b0000_1100, FLUSH);
        vt[7]  = mk(6'b000010, 8'b0000_0000, RUN);
        vt[8]  = mk(6'b000110, 8'b0001_0010, RUN);
        vt[9]  = mk(6'b000110, 8'b0001_0010, RUN);
        vt[10] = mk(6'b000010, 8'b0000_0000, RUN);
        vt[11] = mk(6'b000000, 8'b0001_0000, RUN);
        vt[12] = mk(6'b000000, 8'b0001_0000, WAIT_MEM);
        vt[13] = mk(6'b000000, 8'b0001_0000, WAIT_MEM);
        vt[14] = mk(6'b000010, 8'b0000_0000, WAIT_MEM);
        vt[15] = mk(6'b000010, 8'b0000_0000, RUN);
        vt[16] = mk(6'b000000, 8'b0001_0000, RUN);
        vt[17] = mk(6'b100000, 8'b1000_1100, WAIT_MEM);
        vt[18] = mk(6'b000010, 8'b0000_1100, FLUSH);
        vt[19] = mk(6'b000010, 8'b0000_0000, RUN);
        vt[20] = mk(6'b100011, 8'b0001_0000, RUN);
        vt[21] = mk(6'b100010, 8'b0001_0001, HALT);
        vt[22] = mk(6'b000000, 8'b0001_0001, HALT);

        do_reset();
        check("reset_state", st_a, RUN);
        check("reset_redirect_cnt", redir_a, 0);
        check("reset_stall_cnt", scnt_a, 0);

        foreach (vt[i]) step(vt[i].in, 1'b1, vt[i].exp);
        check("seq_redirect_cnt", redir_a, 2);
        check("seq_stall_cnt", scnt_a, 9);
        check("seq_halted", halted_a, 1'b1);

        // Reset must pull the controller out of HALT and clear the counters.
        do_reset();
        check("post_halt_state", st_a, RUN);
        check("post_halt_redirect_cnt", redir_a, 0);
        check("post_halt_stall_cnt", scnt_a, 0);

        for (int i = 0; i < 20; i++) step(6'b000110, 1'b0, '0);
        check("sat_stall_cnt_b", scnt_b, 4'd15);
        check("unsat_stall_cnt_a", scnt_a, 20);

        // Reset while in FLUSH.
        step(6'b001010, 1'b0, '0);
        do_reset();
        check("reset_mid_flush", st_a, RUN);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                rin[5] = ($urandom_range(0, 9) == 0);
                rin[4] = ($urandom_range(0, 9) == 0);
                rin[3] = ($urandom_range(0, 7) == 0);
                rin[2] = ($urandom_range(0, 5) == 0);
                rin[1] = ($urandom_range(0, 3) != 0);
                rin[0] = ($urandom_range(0, 79) == 0);
                step(rin, 1'b0, '0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
